dmadd_cmd_sequencer: RTL

Upstream control stage for the delta-MADD engine. Accepts a byte-wide command stream over a valid/ready handshake and buffers it in a small FIFO. Decodes each command into the engine's cycle-exact control pattern: index, data, insn, load, run and a stretched engine reset. Reports busy, per-run completion and malformed-command status to the host.

---
 rtl/dmadd_pkg.sv | 21 ++
 rtl/dmadd_cmd_fifo.sv | 35 +++
 rtl/dmadd_cmd_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/dmadd_pkg.sv
// dmadd_pkg: opcodes, instruction codes, command field positions and FSM states shared by the sequencer
package dmadd_pkg;
  localparam logic [1:0] OP_INIT = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_SRST = 2'b11;
  localparam logic [1:0] INSN_MIN  = 2'b00;
  localparam logic [1:0] INSN_MAX  = 2'b01;
  localparam logic [1:0] INSN_MADD = 2'b10;
  localparam int OP_HI  = 7;
  localparam int OP_LO  = 6;
  localparam int ARG_HI = 5;
  localparam int IDX_HI = 7;
  localparam int IDX_LO = 4;
  localparam int DAT_HI = 3;
  localparam int DAT_LO = 0;
  typedef enum logic [2:0] {IDLE, LOAD_WAIT, LOAD_ISSUE, RUN, SRST, DONE} state_t;
  function automatic logic insn_ok(input logic [1:0] v);
    return v inside {INSN_MIN, INSN_MAX, INSN_MADD};
  endfunction
endpackage

// File: rtl/dmadd_cmd_fifo.sv
// dmadd_cmd_fifo: synchronous byte FIFO with full/empty flags and no bypass paths
module dmadd_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic push, pop;
  always_comb begin
    empty = wp == rp;
    full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    push = wr_en && !full;
    pop = rd_en && !empty;
    rd_data = mem[rp[AW-1:0]];
  end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(push);
      rp <= rp + (AW+1)'(pop);
    end
endmodule

// File: rtl/dmadd_cmd_sequencer.sv
// dmadd_cmd_sequencer: buffers command bytes and turns them into cycle-exact delta-MADD engine controls
module dmadd_cmd_sequencer
  import dmadd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RST_CYCLES = 2,
  parameter int RUN_W = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       dm_rst_n,
  output logic [3:0] dm_index,
  output logic [3:0] dm_data,
  output logic [1:0] dm_insn,
  output logic       dm_load,
  output logic       dm_run,
  output logic       busy,
  output logic       done,
  output logic       err
);
  localparam logic [RUN_W-1:0] ONE = RUN_W'(1);
  localparam logic [RUN_W-1:0] RST_LAST = RUN_W'(RST_CYCLES - 1);
  state_t st, nst;
  logic [RUN_W-1:0] cnt, ncnt;
  logic [1:0] mode, nmode;
  logic [3:0] nidx, ndat;
  logic [7:0] rd;
  logic rdy, full, empty, hdr, pop, nerr, o_rst_n, o_load, o_run, o_done;

  dmadd_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(cmd_valid && cmd_ready),
    .wr_data(cmd_data),
    .rd_en(pop),
    .rd_data(rd),
    .full(full),
    .empty(empty)
  );

  assign cmd_ready = rdy && !full;
  assign busy = !empty || st != IDLE;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= SRST;
      cnt <= '0;
      mode <= INSN_MIN;
      err <= 1'b0;
      rdy <= 1'b0;
      dm_rst_n <= 1'b0;
      dm_index <= '0;
      dm_data <= '0;
      dm_insn <= INSN_MIN;
      dm_load <= 1'b0;
      dm_run <= 1'b0;
      done <= 1'b0;
    end else begin
      st <= nst;
      cnt <= ncnt;
      mode <= nmode;
      err <= nerr;
      rdy <= 1'b1;
      dm_rst_n <= o_rst_n;
      dm_index <= nidx;
      dm_data <= ndat;
      dm_insn <= nmode;
      dm_load <= o_load;
      dm_run <= o_run;
      done <= o_done;
    end

  // a new header may be taken in idle or in the final cycle of any command
  always_comb begin
    hdr = !empty && (st == IDLE || st == LOAD_ISSUE || st == DONE || (st == SRST && cnt == RST_LAST));
    pop = hdr || (st == LOAD_WAIT && !empty);
    nst = st;
    ncnt = cnt;
    nmode = mode;
    nerr = err;
    nidx = dm_index;
    ndat = dm_data;
    if (hdr)
      case (rd[OP_HI:OP_LO])
        OP_INIT: begin
          nst = IDLE;
          nmode = insn_ok(rd[1:0]) ? rd[1:0] : mode;
          nerr = err || !insn_ok(rd[1:0]);
        end
        OP_LOAD: nst = LOAD_WAIT;
        OP_RUN: begin
          nst = RUN;
          ncnt = rd[RUN_W-1:0] - ONE;
        end
        default: begin
          nst = SRST;
          ncnt = '0;
          nmode = INSN_MIN;
          nerr = err || |rd[ARG_HI:0];
        end
      endcase
    else
      case (st)
        LOAD_WAIT: if (!empty) begin
          nst = LOAD_ISSUE;
          nidx = rd[IDX_HI:IDX_LO];
          ndat = rd[DAT_HI:DAT_LO];
        end
        RUN: begin
          nst = cnt == '0 ? DONE : RUN;
          ncnt = cnt - ONE;
        end
        SRST: begin
          nst = cnt == RST_LAST ? IDLE : SRST;
          ncnt = cnt + ONE;
        end
        default: nst = IDLE;
      endcase
  end

  always_comb begin
    o_rst_n = nst != SRST;
    o_load = nst == LOAD_ISSUE;
    o_run = nst == RUN;
    o_done = nst == DONE;
  end
endmodule
